// File: rtl/ts_packet_sender.sv
// Purpose     : parallel MPEG-TS byte transmitter fed from a double-buffered 188-byte packet RAM.
// Latency     : first byte of a committed packet is driven within BYTE_DIV+1 clk cycles when idle and enabled.
// Backpressure: buffer_free=0 while a committed packet waits for its bank swap; host writes and commits are dropped then.
//
// Ports:
//   clk, rst (sync, active-high)  | enable, repeat_enable : start control
//   wr_en/wr_index/wr_data        : 32-bit word writes into the fill bank (index 0..46, others ignored)
//   commit                        : fill bank complete; buffer_free mirrors !pending
//   busy, sent_count              : packet/gap in progress, completed-packet counter (wraps)
//   mpeg_clk/data/valid/sync      : TS byte interface, data stable across the rising edge of mpeg_clk
//
// Build option: define TS_CC_INSERT_EN to overwrite bits [3:0] of byte 3 with a per-packet
// continuity counter on output (RAM untouched). Without it every byte is sent verbatim.

module ts_packet_sender #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int BYTE_DIV           = 4,
    parameter int GAP_BYTES          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          repeat_enable,
    input  logic                          wr_en,
    input  logic [31:0]                   wr_index,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
    input  logic                          commit,
    output logic                          buffer_free,
    output logic                          busy,
    output logic [31:0]                   sent_count,
    output logic                          mpeg_clk,
    output logic [7:0]                    mpeg_data,
    output logic                          mpeg_valid,
    output logic                          mpeg_sync
);

    localparam int WORDS     = 47;
    localparam int PW        = (BYTE_DIV > 1) ? $clog2(BYTE_DIV) : 1;
    localparam int GW        = (GAP_BYTES > 1) ? $clog2(GAP_BYTES) : 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]                    state;
    logic [PW-1:0]                 phase;
    logic [PW-1:0]                 phase_nxt;
    logic                          tick;
    logic                          pending;
    logic                          has_packet;
    logic                          active_bank;
    logic [7:0]                    byte_idx;
    logic [GW-1:0]                 gap_cnt;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram [2][WORDS];

    logic                          decide;
    logic                          end_pkt;
    logic                          start_new;
    logic                          start_rep;
    logic                          rd_bank;
    logic [7:0]                    rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic [7:0]                    rd_byte;

`ifdef TS_CC_INSERT_EN
    logic [3:0]                    cc;
`endif

    // Free-running byte-time divider; the byte clock is derived from it even when idle.
    assign tick      = (phase == PW'(BYTE_DIV - 1));
    assign phase_nxt = tick ? '0 : phase + 1'b1;

    assign buffer_free = !pending;
    assign busy        = (state != ST_IDLE);

    // decide marks a tick that acts as an IDLE start decision: plain IDLE, the last gap
    // byte-time, or the end of a packet when there is no gap at all.
    always_comb begin
        decide  = 1'b0;
        end_pkt = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: decide = 1'b1;
                ST_SEND: begin
                    if (byte_idx == 8'd187) begin
                        end_pkt = 1'b1;
                        decide  = (GAP_BYTES == 0);
                    end
                end
                ST_GAP:  decide = (gap_cnt == GW'(GAP_BYTES - 1));
                default: decide = 1'b1;
            endcase
        end
        start_new = decide && enable && pending;
        start_rep = decide && enable && !pending && repeat_enable && has_packet;
        // A fresh packet is read from the bank that is about to become active.
        rd_bank   = start_new ? !active_bank : active_bank;
        rd_idx    = (start_new || start_rep) ? 8'd0 : byte_idx + 8'd1;
    end

    assign rd_word = ram[rd_bank][rd_idx[7:2]];

    always_comb begin
        rd_byte = rd_word[{rd_idx[1:0], 3'b000} +: 8];
`ifdef TS_CC_INSERT_EN
        if (rd_idx == 8'd3) begin
            rd_byte[3:0] = cc;
        end
`endif
    end

    // Packet RAM is deliberately not reset. Writes only land in the fill bank while no commit is pending.
    always_ff @(posedge clk) begin
        if (wr_en && !pending && (wr_index < 32'd47)) begin
            ram[!active_bank][wr_index[5:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= '0;
            mpeg_clk    <= 1'b0;
            pending     <= 1'b0;
            has_packet  <= 1'b0;
            active_bank <= 1'b0;
            byte_idx    <= 8'd0;
            gap_cnt     <= '0;
            sent_count  <= 32'd0;
            mpeg_data   <= 8'd0;
            mpeg_valid  <= 1'b0;
            mpeg_sync   <= 1'b0;
`ifdef TS_CC_INSERT_EN
            cc          <= 4'd0;
`endif
        end else begin
            phase    <= phase_nxt;
            mpeg_clk <= (phase_nxt >= PW'(BYTE_DIV / 2));

            // The swap consumes pending; a commit in the same cycle sees pending=1 and is dropped.
            if (start_new) begin
                pending     <= 1'b0;
                active_bank <= !active_bank;
            end else if (commit && !pending) begin
                pending    <= 1'b1;
                has_packet <= 1'b1;
            end

            if (tick) begin
                if (start_new || start_rep) begin
                    state      <= ST_SEND;
                    byte_idx   <= 8'd0;
                    mpeg_valid <= 1'b1;
                    mpeg_sync  <= 1'b1;
                    mpeg_data  <= rd_byte;
                end else if (state == ST_SEND && !end_pkt) begin
                    byte_idx  <= rd_idx;
                    mpeg_sync <= 1'b0;
                    mpeg_data <= rd_byte;
                end else if (end_pkt && (GAP_BYTES != 0)) begin
                    state      <= ST_GAP;
                    gap_cnt    <= '0;
                    mpeg_valid <= 1'b0;
                    mpeg_sync  <= 1'b0;
                    mpeg_data  <= 8'd0;
                end else if (state == ST_GAP && !decide) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end else begin
                    state      <= ST_IDLE;
                    mpeg_valid <= 1'b0;
                    mpeg_sync  <= 1'b0;
                    mpeg_data  <= 8'd0;
                end
            end

            if (end_pkt) begin
                sent_count <= sent_count + 32'd1;
`ifdef TS_CC_INSERT_EN
                cc         <= cc + 4'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ts_packet_sender.sv
// Testbench for ts_packet_sender: a receiver-side model assembles packets on mpeg_clk rising
// edges and compares them with the packets the host committed (queue + repeat of the last one).

module tb_ts_packet_sender;

    localparam int BYTE_DIV  = 4;
    localparam int GAP_BYTES = 2;
    localparam int NB        = 188;
    typedef logic [NB*8-1:0] pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        repeat_enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_index = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic        commit = 1'b0;
    logic        buffer_free;
    logic        busy;
    logic [31:0] sent_count;
    logic        mpeg_clk;
    logic [7:0]  mpeg_data;
    logic        mpeg_valid;
    logic        mpeg_sync;

    int tests = 0;
    int fails = 0;

    // Host / receiver model state
    pkt_t       host_pkt;
    pkt_t       stage;
    pkt_t       last_pkt;
    pkt_t       cur_pkt;
    pkt_t       rx_buf;
    pkt_t       rx_last;
    pkt_t       pend_q[$];
    logic [7:0] cc_seen[$];
    bit         m_pending = 0;
    bit         have_last = 0;
    bit         have_prev = 0;
    bit         mclk_known = 0;
    bit         prev_mclk = 0;
    bit         prev_rst = 1;
    logic [9:0] prev_out = '0;
    int         model_sent = 0;
    int         rx_pos = 0;
    int         rx_pkts = 0;
    int         gap_run = 0;
    int         mclk_run = 0;

    always #5 clk = ~clk;

    ts_packet_sender #(
        .C_S_AXI_DATA_WIDTH(32),
        .BYTE_DIV(BYTE_DIV),
        .GAP_BYTES(GAP_BYTES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .repeat_enable(repeat_enable),
        .wr_en(wr_en),
        .wr_index(wr_index),
        .wr_data(wr_data),
        .commit(commit),
        .buffer_free(buffer_free),
        .busy(busy),
        .sent_count(sent_count),
        .mpeg_clk(mpeg_clk),
        .mpeg_data(mpeg_data),
        .mpeg_valid(mpeg_valid),
        .mpeg_sync(mpeg_sync)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Receiver: one compare process covering byte clock shape, output stability and packet content.
    always @(negedge clk) begin
        logic [7:0] eb;
        bit         src;
        if (rst) begin
            rx_pos     = 0;
            have_prev  = 0;
            gap_run    = 0;
            mclk_known = 0;
            have_last  = 0;
            m_pending  = 0;
            model_sent = 0;
            pend_q.delete();
            cc_seen.delete();
        end else begin
            if (mpeg_clk != prev_mclk) begin
                if (mclk_known) check("mclk_half_period", mclk_run, BYTE_DIV / 2);
                mclk_known = 1;
                mclk_run   = 1;
            end else begin
                mclk_run++;
            end
            if (!prev_rst && ({mpeg_valid, mpeg_sync, mpeg_data} != prev_out))
                check("out_change_on_mclk_fall", {30'd0, prev_mclk, mpeg_clk}, 32'd2);
            if (mpeg_clk && !prev_mclk) begin
                if (mpeg_valid) begin
                    if (rx_pos == 0) begin
                        src = 1;
                        if (pend_q.size() > 0) begin
                            cur_pkt   = pend_q.pop_front();
                            m_pending = 0;
                            last_pkt  = cur_pkt;
                            have_last = 1;
                        end else if (repeat_enable && have_last) begin
                            cur_pkt = last_pkt;
                        end else begin
                            src = 0;
                        end
                        check("pkt_expected", src, 1);
                        if (have_prev) check("gap_min", gap_run >= GAP_BYTES, 1);
                    end
                    eb = cur_pkt[8*rx_pos +: 8];
`ifdef TS_CC_INSERT_EN
                    if (rx_pos == 3) eb[3:0] = model_sent[3:0];
`endif
                    check("data", mpeg_data, eb);
                    check("sync", mpeg_sync, rx_pos == 0);
                    rx_buf[8*rx_pos +: 8] = mpeg_data;
                    if (rx_pos == 3) cc_seen.push_back(mpeg_data);
                    rx_pos++;
                    if (rx_pos == NB) begin
                        rx_pos    = 0;
                        model_sent++;
                        rx_pkts++;
                        rx_last   = rx_buf;
                        have_prev = 1;
                        gap_run   = 0;
                    end
                end else begin
                    check("sync_idle", mpeg_sync, 0);
                    check("no_gap_inside_pkt", rx_pos, 0);
                    gap_run++;
                end
            end
        end
        prev_mclk = mpeg_clk;
        prev_out  = {mpeg_valid, mpeg_sync, mpeg_data};
        prev_rst  = rst;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; wr_en = 0; commit = 0;
        cyc(2);
        rst = 0;
    endtask

    task automatic wr_word(input logic [31:0] idx, input logic [31:0] d);
        wr_en = 1; wr_index = idx; wr_data = d;
        cyc(1);
        wr_en = 0;
        if (!m_pending && idx < 32'd47) host_pkt[32*idx +: 32] = d;
    endtask

    task automatic load_stage();
        for (int w = 0; w < 47; w++) wr_word(w, stage[32*w +: 32]);
    endtask

    task automatic rand_stage();
        for (int w = 0; w < 47; w++) stage[32*w +: 32] = $urandom;
    endtask

    task automatic do_commit();
        commit = 1;
        cyc(1);
        commit = 0;
        if (!m_pending) begin
            pend_q.push_back(host_pkt);
            m_pending = 1;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        cyc(BYTE_DIV + 2);
        while (busy && n < limit) begin
            cyc(1);
            n++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    task automatic wait_pkt_pos(input int pkts, input int pos, input int limit);
        int n = 0;
        while (!(rx_pkts >= pkts && rx_pos >= pos) && n < limit) begin
            cyc(1);
            n++;
        end
        check("reached_pkt_pos", n < limit, 1);
    endtask

    initial begin
        int lat;
        int base;
        int vcount;
        logic [31:0] sc_snap;

        // Reset values
        cyc(2);
        check("rst_buffer_free", buffer_free, 1);
        check("rst_busy", busy, 0);
        check("rst_sent_count", sent_count, 0);
        check("rst_mpeg_clk", mpeg_clk, 0);
        check("rst_mpeg_data", mpeg_data, 0);
        check("rst_mpeg_valid", mpeg_valid, 0);
        check("rst_mpeg_sync", mpeg_sync, 0);
        rst = 0;
        cyc(3);

        // 1: counting pattern with 0x47 sync byte, latency and literal bytes
        enable = 1;
        for (int i = 0; i < NB; i++) stage[8*i +: 8] = 8'(i);
        stage[7:0] = 8'h47;
        load_stage();
        do_commit();
        lat = 1;
        while (!mpeg_valid && lat < 20) begin
            cyc(1);
            lat++;
        end
        check("first_byte_latency_ok", lat <= BYTE_DIV + 1, 1);
        check("busy_in_send", busy, 1);
        check("buffer_free_after_swap1", buffer_free, 1);
        wait_idle(1200);
        check("t1_sent_count", sent_count, 1);
        check("t1_byte0", rx_last[7:0], 32'h47);
        check("t1_byte1", rx_last[15:8], 32'h01);
        check("t1_byte100", rx_last[8*100 +: 8], 32'h64);
        check("t1_byte187", rx_last[8*187 +: 8], 32'hBB);
        check("t1_valid_low", mpeg_valid, 0);

        // 2: repeat with a single commit; timing pins gap length to exactly GAP_BYTES
        do_reset();
        rand_stage();
        load_stage();
        repeat_enable = 1;
        do_commit();
        cyc(2267);
        check("rep_sent_at_2268", sent_count, 2);
        cyc(10);
        check("rep_sent_at_2278", sent_count, 3);
        wait_pkt_pos(3, 5, 1000);
        repeat_enable = 0;
        wait_idle(1200);
        check("rep_sent_final", sent_count, model_sent);

        // 3: A then B while A in flight; third commit while pending is ignored
        base = rx_pkts;
        rand_stage();
        load_stage();
        do_commit();
        wait_pkt_pos(base, 10, 200);
        check("bf_after_a_swap", buffer_free, 1);
        rand_stage();
        load_stage();
        do_commit();
        check("bf_b_pending", buffer_free, 0);
        rand_stage();
        load_stage();
        do_commit();
        check("bf_still_pending", buffer_free, 0);
        wait_pkt_pos(base + 1, 1, 1500);
        check("bf_after_b_swap", buffer_free, 1);
        wait_idle(1200);
        check("ab_packet_count", rx_pkts - base, 2);
        check("ab_sent_count", sent_count, model_sent);

        // 4: reset at byte 100 aborts the packet, nothing follows without a new commit
        base = rx_pkts;
        rand_stage();
        load_stage();
        do_commit();
        wait_pkt_pos(base, 100, 1000);
        rst = 1;
        cyc(1);
        check("abort_valid", mpeg_valid, 0);
        check("abort_sync", mpeg_sync, 0);
        check("abort_sent_count", sent_count, 0);
        check("abort_buffer_free", buffer_free, 1);
        check("abort_busy", busy, 0);
        rst = 0;
        repeat_enable = 1;
        vcount = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            if (mpeg_valid) vcount++;
        end
        check("no_output_after_abort", vcount, 0);
        check("abort_sent_stays_0", sent_count, 0);
        repeat_enable = 0;

        // 5: out-of-range indices ignored; enable=0 holds the packet back
        rand_stage();
        stage[32*46 +: 32] = stage[32*46 +: 32] | 32'h1;
        load_stage();
        wr_word(47, 32'hFFFF_FFFF);
        wr_word(200, 32'hA5A5_A5A5);
        enable = 0;
        do_commit();
        cyc(50);
        check("held_by_enable", busy, 0);
        sc_snap = sent_count;
        enable = 1;
        wait_idle(1200);
        check("oor_sent_inc", sent_count - sc_snap, 1);
        check("oor_word8", rx_last[32*8 +: 32], stage[32*8 +: 32]);
        check("oor_word46", rx_last[32*46 +: 32], stage[32*46 +: 32]);

        // 6: byte 3 stored as 0x1F over 17 repeated packets
        do_reset();
        rand_stage();
        stage[8*3 +: 8] = 8'h1F;
        load_stage();
        repeat_enable = 1;
        do_commit();
        begin
            int n = 0;
            while (cc_seen.size() < 17 && n < 17 * 800) begin
                cyc(1);
                n++;
            end
        end
        repeat_enable = 0;
        wait_idle(1200);
        check("cc_pkt_count", cc_seen.size(), 17);
        if (cc_seen.size() >= 17) begin
`ifdef TS_CC_INSERT_EN
            check("cc_first", cc_seen[0], 32'h10);
            check("cc_second", cc_seen[1], 32'h11);
            check("cc_16th", cc_seen[15], 32'h1F);
            check("cc_wrap", cc_seen[16], 32'h10);
`else
            check("cc_first", cc_seen[0], 32'h1F);
            check("cc_second", cc_seen[1], 32'h1F);
            check("cc_16th", cc_seen[15], 32'h1F);
            check("cc_wrap", cc_seen[16], 32'h1F);
`endif
        end
        check("cc_sent_count", sent_count, 17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
